ram_request_arbiter: RTL and testbench

//  Arbitrates between the instruction-fetch and data requesters for one single-port RAM sim model.

---
 rtl/ram_request_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_request_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_request_arbiter.sv
// Two-way arbiter in front of a single-port RAM model. Instruction fetch and
// data requesters share the RAM; the granted request is captured in hold
// registers and presented on the RAM pins until the RAM reports completion.
// Every access is followed by an IDLE cycle, so the RAM always sees its
// inputs change and restarts its latency count.
module ram_request_arbiter #(
  parameter  int ADDR_BITS = 13,
  parameter  int N_BYTES   = 4,
  localparam int N_BITS    = N_BYTES * 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  // instruction requester
  input  logic                 i_ren,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic [N_BITS-1:0]    i_rdata,
  output logic                 i_busy,
  // data requester
  input  logic                 d_ren,
  input  logic                 d_wen,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [N_BITS-1:0]    d_wdata,
  input  logic [N_BYTES-1:0]   d_byte_en,
  output logic [N_BITS-1:0]    d_rdata,
  output logic                 d_busy,
  // RAM side
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [N_BITS-1:0]    ram_wdata,
  output logic [N_BYTES-1:0]   ram_byte_en,
  output logic                 ram_ren,
  output logic                 ram_wen,
  input  logic [N_BITS-1:0]    ram_rdata,
  input  logic                 ram_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // The access owner is carried by the state itself (I_ACC vs D_ACC).
  state_t               state_q, state_d;
  grant_t               last_grant_q, last_grant_d;
  logic [ADDR_BITS-1:0] hold_addr_q, hold_addr_d;
  logic [N_BITS-1:0]    hold_wdata_q, hold_wdata_d;
  logic [N_BYTES-1:0]   hold_be_q, hold_be_d;
  logic                 hold_ren_q, hold_ren_d;
  logic                 hold_wen_q, hold_wen_d;

  logic d_req;
  logic pick_data;

  assign d_req = d_ren | d_wen;
  // Data wins when it is alone, or when both are pending and instruction had the last grant.
  assign pick_data = d_req & (~i_ren | (last_grant_q == GRANT_INSTR));

  // Next-state, request capture and requester busy handshakes.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_be_d    = hold_be_q;
    hold_ren_d   = hold_ren_q;
    hold_wen_d   = hold_wen_q;
    i_busy       = 1'b1;
    d_busy       = 1'b1;

    case (state_q)
      IDLE: begin
        if (pick_data) begin
          state_d      = D_ACC;
          hold_addr_d  = d_addr;
          hold_wdata_d = d_wdata;
          hold_be_d    = d_byte_en;
          // a write takes precedence when both read and write are requested
          hold_wen_d   = d_wen;
          hold_ren_d   = ~d_wen;
        end else if (i_ren) begin
          state_d      = I_ACC;
          hold_addr_d  = i_addr;
          hold_wdata_d = '0;
          hold_be_d    = '1;
          hold_ren_d   = 1'b1;
          hold_wen_d   = 1'b0;
        end
      end
      I_ACC: begin
        if (!ram_busy) begin
          i_busy       = 1'b0;
          last_grant_d = GRANT_INSTR;
          state_d      = IDLE;
        end
      end
      D_ACC: begin
        if (!ram_busy) begin
          d_busy       = 1'b0;
          last_grant_d = GRANT_DATA;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and hold registers, asynchronously cleared by nRST.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_INSTR;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_be_q    <= '0;
      hold_ren_q   <= 1'b0;
      hold_wen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_be_q    <= hold_be_d;
      hold_ren_q   <= hold_ren_d;
      hold_wen_q   <= hold_wen_d;
    end
  end

  // RAM pins come only from the hold registers; enables are gated off in IDLE.
  assign ram_addr    = hold_addr_q;
  assign ram_wdata   = hold_wdata_q;
  assign ram_byte_en = hold_be_q;
  assign ram_ren     = hold_ren_q & (state_q != IDLE);
  assign ram_wen     = hold_wen_q & (state_q != IDLE);

  assign i_rdata = ram_rdata;
  assign d_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Bench for ram_request_arbiter: a latency-configurable RAM model plus
// directed scenarios and a randomized two-requester run checked against a
// transaction-level reference (memory image, round-robin and timing rules).
module tb_ram_request_arbiter;

  localparam int AB = 13;
  localparam int NB = 4;
  localparam int DW = NB * 8;

  logic          CLK;
  logic          nRST;
  logic          i_ren;
  logic [AB-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_busy;
  logic          d_ren;
  logic          d_wen;
  logic [AB-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [NB-1:0] d_byte_en;
  logic [DW-1:0] d_rdata;
  logic          d_busy;
  logic [AB-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [NB-1:0] ram_byte_en;
  logic          ram_ren;
  logic          ram_wen;
  logic [DW-1:0] ram_rdata;
  logic          ram_busy;

  int n_checks = 0;
  int n_fail   = 0;

  ram_request_arbiter #(.ADDR_BITS(AB), .N_BYTES(NB)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_busy(d_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byte_en(ram_byte_en),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_rdata(ram_rdata), .ram_busy(ram_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- RAM model ----------------
  // Latency restarts whenever the inputs change; busy drops once the inputs
  // have been stable for ram_lat cycles after first being sampled.
  logic [DW-1:0] mem [0:(1<<AB)-1];
  int unsigned   ram_lat = 0;
  int unsigned   cnt = 0;
  logic [AB-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [NB-1:0] s_be;
  logic          s_ren, s_wen;
  logic          pre_we = 1'b0;
  logic [AB-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic          active, same;

  assign active = ram_ren | ram_wen;
  assign same = (s_addr == ram_addr) && (s_wdata == ram_wdata) && (s_be == ram_byte_en) &&
                (s_ren == ram_ren) && (s_wen == ram_wen);
  assign ram_busy  = !(active && same && (cnt == ram_lat));
  assign ram_rdata = (ram_ren && !ram_busy) ? mem[ram_addr] : '0;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (ram_wen && !ram_busy)
      for (int b = 0; b < NB; b++)
        if (ram_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (active && same) begin
      if (cnt < ram_lat) cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
    s_addr  <= ram_addr;
    s_wdata <= ram_wdata;
    s_be    <= ram_byte_en;
    s_ren   <= ram_ren;
    s_wen   <= ram_wen;
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload(input logic [AB-1:0] a, input logic [DW-1:0] d);
    @(negedge CLK);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    i_ren = 0; d_ren = 0; d_wen = 0;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Wait for the owner's busy to drop (request must already be driven);
  // lat is the number of clock edges since the request was set, -1 on timeout.
  task automatic wait_done(input bit is_d, output int lat, output logic [DW-1:0] data,
                           output bit other_low);
    lat = -1; data = '0; other_low = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (is_d ? !i_busy : !d_busy) other_low = 1'b1;
      if (is_d ? !d_busy : !i_busy) begin
        lat  = n;
        data = is_d ? d_rdata : i_rdata;
        if (is_d) begin d_ren = 0; d_wen = 0; end else i_ren = 0;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_ren = 0; d_ren = 0; d_wen = 0; i_addr = '0; d_addr = '0; d_wdata = '0; d_byte_en = '0;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++; if (i_busy !== 1'b1) begin n_fail++; $display("FAIL reset_i_busy got %b want 1", i_busy); end
    n_checks++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL reset_d_busy got %b want 1", d_busy); end
    n_checks++; if (ram_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ram_ren got %b want 0", ram_ren); end
    n_checks++; if (ram_wen !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wen got %b want 0", ram_wen); end
    n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
    n_checks++; if (ram_byte_en !== '0) begin n_fail++; $display("FAIL reset_ram_be got %h want 0", ram_byte_en); end
    nRST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      n_checks++;
      if ({ram_ren, ram_wen, i_busy, d_busy} !== 4'b0011) begin
        n_fail++; $display("FAIL idle_after_reset got ren/wen/ib/db=%b want 0011", {ram_ren, ram_wen, i_busy, d_busy});
      end
    end
  endtask

  task automatic test_instr_read();
    int lat; logic [DW-1:0] data; bit other_low;
    ram_lat = 0;
    preload(13'h10, 32'hDEADBEEF);
    i_addr = 13'h10; i_ren = 1'b1;
    wait_done(1'b0, lat, data, other_low);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL instr_latency got %0d want 2", lat); end
    n_checks++; if (data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL instr_rdata got %h want deadbeef", data); end
    n_checks++; if (other_low !== 1'b0) begin n_fail++; $display("FAIL instr_d_busy_low got %b want 0", other_low); end
    @(negedge CLK);
    n_checks++; if (i_busy !== 1'b1) begin n_fail++; $display("FAIL instr_busy_one_cycle got %b want 1", i_busy); end
  endtask

  task automatic test_byte_write();
    int lat; logic [DW-1:0] data; bit other_low;
    ram_lat = 0;
    preload(13'h20, 32'h11223344);
    d_addr = 13'h20; d_wdata = 32'hAABBCCDD; d_byte_en = 4'b0101; d_wen = 1'b1; d_ren = 1'b0;
    wait_done(1'b1, lat, data, other_low);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL write_latency got %0d want 2", lat); end
    n_checks++; if (other_low !== 1'b0) begin n_fail++; $display("FAIL write_i_busy_low got %b want 0", other_low); end
    @(negedge CLK);
    n_checks++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_one_cycle got %b want 1", d_busy); end
    d_ren = 1'b1; d_wdata = '0;
    wait_done(1'b1, lat, data, other_low);
    n_checks++; if (data !== 32'h11BB33DD) begin n_fail++; $display("FAIL masked_readback got %h want 11bb33dd", data); end
    @(negedge CLK);
  endtask

  task automatic test_contention();
    bit got_d [4];
    int at [4];
    logic [DW-1:0] dat [4];
    int k;
    do_reset();
    ram_lat = 0;
    i_addr = 13'h10; d_addr = 13'h20; d_wen = 1'b0;
    i_ren = 1'b1; d_ren = 1'b1;
    k = 0;
    for (int n = 1; n <= 80 && k < 4; n++) begin
      @(negedge CLK);
      n_checks++;
      if (!i_busy && !d_busy) begin n_fail++; $display("FAIL contention_both_done at cycle %0d", n); end
      if (!d_busy || !i_busy) begin
        got_d[k] = !d_busy; at[k] = n; dat[k] = !d_busy ? d_rdata : i_rdata;
        k++;
      end
    end
    i_ren = 1'b0; d_ren = 1'b0;
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL contention_count got %0d want 4", k); end
    for (int j = 0; j < k; j++) begin
      n_checks++;
      if (got_d[j] !== ((j % 2) == 0)) begin n_fail++; $display("FAIL contention_order[%0d] got data=%b want %b", j, got_d[j], (j % 2) == 0); end
      n_checks++;
      if (at[j] !== 2 + 3 * j) begin n_fail++; $display("FAIL contention_time[%0d] got %0d want %0d", j, at[j], 2 + 3 * j); end
      n_checks++;
      if (dat[j] !== (((j % 2) == 0) ? 32'h11BB33DD : 32'hDEADBEEF)) begin
        n_fail++; $display("FAIL contention_data[%0d] got %h", j, dat[j]);
      end
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_stability();
    int lat; logic [DW-1:0] data;
    do_reset();
    ram_lat = 3;
    preload(13'h30, 32'hC0FFEE00);
    preload(13'h31, 32'h12345678);
    d_addr = 13'h30; d_ren = 1'b1; d_wen = 1'b0;
    lat = -1; data = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      n_checks++;
      if (ram_addr !== 13'h30) begin n_fail++; $display("FAIL stable_ram_addr cycle %0d got %h want 030", n, ram_addr); end
      if (!d_busy) begin lat = n; data = d_rdata; d_ren = 1'b0; break; end
      if (n == 2) d_addr = 13'h31;
    end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL stable_latency got %0d want 5", lat); end
    n_checks++; if (data !== 32'hC0FFEE00) begin n_fail++; $display("FAIL stable_rdata got %h want c0ffee00", data); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int lat; logic [DW-1:0] data; bit other_low;
    do_reset();
    ram_lat = 5;
    @(negedge CLK);
    d_addr = 13'h50; d_wdata = 32'h55AA55AA; d_byte_en = '1; d_wen = 1'b1; d_ren = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++; if (ram_wen !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_wen got %b want 1", ram_wen); end
    #2 nRST = 1'b0;
    #1;
    n_checks++; if (ram_wen !== 1'b0) begin n_fail++; $display("FAIL midreset_ram_wen got %b want 0", ram_wen); end
    n_checks++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL midreset_d_busy got %b want 1", d_busy); end
    d_wen = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    ram_lat = 0;
    d_addr = 13'h10; d_ren = 1'b1;
    wait_done(1'b1, lat, data, other_low);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL after_reset_latency got %0d want 2", lat); end
    n_checks++; if (data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL after_reset_rdata got %h want deadbeef", data); end
    @(negedge CLK);
  endtask

  // Randomized traffic from both requesters. Reference: memory image updated
  // by completed writes; a requester already waiting when the other completes
  // must be served next, exactly lat+3 cycles later.
  task automatic test_random();
    logic [DW-1:0] ref_mem [8];
    bit i_pend, d_pend, d_write;
    int unsigned i_wait, d_wait;
    int i_idx, d_idx;
    logic [DW-1:0] d_wd;
    logic [NB-1:0] d_be;
    int done_cnt, prev_c;
    bit have_prev, prev_d, other_pend_prev, stop_issue;
    int cyc;

    do_reset();
    ram_lat = $urandom_range(0, 3);
    for (int a = 0; a < 8; a++) begin
      ref_mem[a] = $urandom;
      preload(13'h40 + 13'(a), ref_mem[a]);
    end
    i_pend = 0; d_pend = 0; i_wait = 0; d_wait = 0; d_write = 0;
    i_idx = 0; d_idx = 0; d_wd = '0; d_be = '0;
    done_cnt = 0; prev_c = 0; have_prev = 0; prev_d = 0; other_pend_prev = 0; stop_issue = 0;
    cyc = 0;

    while (cyc < 3000 && !(stop_issue && !i_pend && !d_pend)) begin
      @(negedge CLK);
      cyc++;
      n_checks++;
      if (!i_busy && !d_busy) begin n_fail++; $display("FAIL rand_both_done at cycle %0d", cyc); end
      if (!i_busy || !d_busy) begin
        bit is_d;
        is_d = !d_busy;
        n_checks++;
        if ((is_d ? d_pend : i_pend) !== 1'b1) begin n_fail++; $display("FAIL rand_unrequested_done owner_d=%b cycle %0d", is_d, cyc); end
        if (have_prev && other_pend_prev) begin
          n_checks++;
          if (is_d !== !prev_d) begin n_fail++; $display("FAIL rand_round_robin got data=%b want %b cycle %0d", is_d, !prev_d, cyc); end
          n_checks++;
          if (cyc - prev_c !== int'(ram_lat) + 3) begin
            n_fail++; $display("FAIL rand_gap got %0d want %0d cycle %0d", cyc - prev_c, ram_lat + 3, cyc);
          end
        end
        if (is_d) begin
          if (d_write) begin
            for (int b = 0; b < NB; b++)
              if (d_be[b]) ref_mem[d_idx][8*b +: 8] = d_wd[8*b +: 8];
          end else begin
            n_checks++;
            if (d_rdata !== ref_mem[d_idx]) begin n_fail++; $display("FAIL rand_d_rdata addr %0d got %h want %h", d_idx, d_rdata, ref_mem[d_idx]); end
          end
          other_pend_prev = i_pend;
          d_pend = 0; d_ren = 0; d_wen = 0; d_wait = $urandom_range(0, 3);
        end else begin
          n_checks++;
          if (i_rdata !== ref_mem[i_idx]) begin n_fail++; $display("FAIL rand_i_rdata addr %0d got %h want %h", i_idx, i_rdata, ref_mem[i_idx]); end
          other_pend_prev = d_pend;
          i_pend = 0; i_ren = 0; i_wait = $urandom_range(0, 3);
        end
        have_prev = 1; prev_d = is_d; prev_c = cyc;
        done_cnt++;
        if (done_cnt >= 60) stop_issue = 1;
      end
      if (!stop_issue && !i_pend) begin
        if (i_wait == 0) begin
          i_pend = 1; i_idx = $urandom_range(0, 7);
          i_addr = 13'h40 + 13'(i_idx); i_ren = 1;
        end else i_wait--;
      end
      if (!stop_issue && !d_pend) begin
        if (d_wait == 0) begin
          d_pend = 1; d_idx = $urandom_range(0, 7);
          d_write = ($urandom_range(0, 1) == 1);
          d_wd = $urandom; d_be = 4'($urandom_range(0, 15));
          d_addr = 13'h40 + 13'(d_idx); d_wdata = d_wd; d_byte_en = d_be;
          d_wen = d_write;
          d_ren = d_write ? ($urandom_range(0, 1) == 1) : 1'b1;
        end else d_wait--;
      end
    end
    n_checks++;
    if (done_cnt < 60 || i_pend || d_pend) begin
      n_fail++; $display("FAIL rand_timeout got %0d completions pend i=%b d=%b", done_cnt, i_pend, d_pend);
    end
    i_ren = 0; d_ren = 0; d_wen = 0;
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_byte_write();
    test_contention();
    test_stability();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
